// File: rtl/cnn_pkg.sv
// Shared constants and sequencer state encoding for the CNN frame sequencer.
package cnn_pkg;

  localparam int unsigned IMG_PIXELS = 784;
  localparam int unsigned CLASS_W    = 4;
  localparam int unsigned SCORE_W    = 32;
  localparam int unsigned PIX_W      = 8;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StFeed = 3'd1,
    StWait = 3'd2,
    StHold = 3'd3,
    StErr  = 3'd4
  } seq_state_e;

  // Counter width able to hold values 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cnn_frame_sequencer_if.sv
// Host pixel stream, pipeline pixel/result stream and host result handshake.
interface cnn_frame_sequencer_if;
  import cnn_pkg::*;

  logic                      s_valid;
  logic [PIX_W-1:0]          s_data;
  logic                      s_ready;
  logic                      pix_valid;
  logic [PIX_W-1:0]          pix_data;
  logic                      class_valid;
  logic [CLASS_W-1:0]        class_in;
  logic signed [SCORE_W-1:0] score_in;
  logic                      res_valid;
  logic [CLASS_W-1:0]        res_class;
  logic signed [SCORE_W-1:0] res_score;
  logic                      res_ready;

  // Sequencer side.
  modport slave (
    input  s_valid, s_data, class_valid, class_in, score_in, res_ready,
    output s_ready, pix_valid, pix_data, res_valid, res_class, res_score
  );

  // Host / pipeline side.
  modport master (
    output s_valid, s_data, class_valid, class_in, score_in, res_ready,
    input  s_ready, pix_valid, pix_data, res_valid, res_class, res_score
  );

endinterface

// File: rtl/seq_watchdog.sv
// Saturating cycle counter flagging when an enabled interval reaches its limit.
module seq_watchdog #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  output logic             expired
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   cnt_inc;

  assign cnt_inc = {1'b0, cnt_q} + (WIDTH + 1)'(1);

  // Next count: clear wins, otherwise count enabled cycles and hold at limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != limit)) begin
      cnt_d = cnt_inc[WIDTH-1:0];
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // High during the enabled cycle that is the limit-th one since clear.
  assign expired = enable && !clear && (cnt_inc >= {1'b0, limit});

endmodule

// File: rtl/cnn_frame_sequencer.sv
// Feeds one frame of pixels to the CNN pipeline, waits for its class result
// with a timeout, and holds the result for the host.
module cnn_frame_sequencer
  import cnn_pkg::*;
#(
  parameter int unsigned PIXELS      = IMG_PIXELS,
  parameter int unsigned TIMEOUT_CYC = 200000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  cnn_frame_sequencer_if.slave       bus,
  output logic                       busy,
  output logic [15:0]                frame_cnt,
  output logic                       timeout_err
);

  localparam int unsigned PixCntW = cnt_width(PIXELS);
  localparam int unsigned ToCntW  = cnt_width(TIMEOUT_CYC + 1);
  localparam logic [PixCntW-1:0] LastPix = PixCntW'(PIXELS - 1);
  localparam logic [ToCntW-1:0]  ToLimit = ToCntW'(TIMEOUT_CYC);

  seq_state_e                state_q, state_d;
  logic [PixCntW-1:0]        pix_cnt_q, pix_cnt_d;
  logic [15:0]               frame_cnt_q, frame_cnt_d;
  logic                      timeout_err_q, timeout_err_d;
  logic                      s_ready_q, res_valid_q, busy_q;
  logic                      pix_valid_q;
  logic [PIX_W-1:0]          pix_data_q;
  logic [CLASS_W-1:0]        res_class_q;
  logic signed [SCORE_W-1:0] res_score_q;
  logic                      accept, capture;
  logic                      wd_clear, wd_enable, wd_expired;

  // s_ready_q is registered from the next state, so it equals (state_q == StFeed).
  assign accept    = bus.s_valid && s_ready_q;
  assign wd_enable = (state_q == StWait);

  seq_watchdog #(
    .WIDTH (ToCntW)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .limit   (ToLimit),
    .expired (wd_expired)
  );

  // Next-state and counter control; abort overrides every other request.
  always_comb begin
    state_d       = state_q;
    pix_cnt_d     = pix_cnt_q;
    frame_cnt_d   = frame_cnt_q;
    timeout_err_d = timeout_err_q;
    capture       = 1'b0;
    wd_clear      = 1'b0;
    if (abort) begin
      state_d   = StIdle;
      pix_cnt_d = '0;
      wd_clear  = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_d   = StFeed;
            pix_cnt_d = '0;
          end
        end
        StFeed: begin
          if (accept) begin
            if (pix_cnt_q == LastPix) begin
              state_d   = StWait;
              pix_cnt_d = '0;
              wd_clear  = 1'b1;
            end else begin
              pix_cnt_d = pix_cnt_q + PixCntW'(1);
            end
          end
        end
        StWait: begin
          // A result arriving on the expiry cycle still counts.
          if (bus.class_valid) begin
            state_d = StHold;
            capture = 1'b1;
          end else if (wd_expired) begin
            state_d       = StErr;
            timeout_err_d = 1'b1;
          end
        end
        StHold: begin
          if (bus.res_ready) begin
            state_d     = StIdle;
            frame_cnt_d = frame_cnt_q + 16'd1;
          end
        end
        StErr: begin
          if (start) begin
            state_d       = StFeed;
            pix_cnt_d     = '0;
            timeout_err_d = 1'b0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State, counters and state-decoded flags, registered so outputs cannot glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      pix_cnt_q     <= '0;
      frame_cnt_q   <= '0;
      timeout_err_q <= 1'b0;
      s_ready_q     <= 1'b0;
      res_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pix_cnt_q     <= pix_cnt_d;
      frame_cnt_q   <= frame_cnt_d;
      timeout_err_q <= timeout_err_d;
      s_ready_q     <= (state_d == StFeed);
      res_valid_q   <= (state_d == StHold);
      busy_q        <= (state_d != StIdle);
    end
  end

  // Pixel forwarding and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid_q <= 1'b0;
      pix_data_q  <= '0;
      res_class_q <= '0;
      res_score_q <= '0;
    end else begin
      pix_valid_q <= accept && !abort;
      if (accept && !abort) begin
        pix_data_q <= bus.s_data;
      end
      if (capture) begin
        res_class_q <= bus.class_in;
        res_score_q <= bus.score_in;
      end
    end
  end

  assign bus.s_ready   = s_ready_q;
  assign bus.pix_valid = pix_valid_q;
  assign bus.pix_data  = pix_data_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_class = res_class_q;
  assign bus.res_score = res_score_q;
  assign busy          = busy_q;
  assign frame_cnt     = frame_cnt_q;
  assign timeout_err   = timeout_err_q;

endmodule
